// File: rtl/xor_fault_monitor.sv
// Drives the 6-bit vector into the laser-target XOR gate, samples the gate output
// after a settle window, and records mismatches (laser-induced faults).
module xor_fault_monitor #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clear,
  input  logic             q_in,
  output logic [5:0]       a_out,
  output logic             busy,
  output logic             sweep_done,
  output logic             fault,
  output logic [CNT_W-1:0] fault_count,
  output logic [5:0]       fault_vec
);

  localparam int unsigned VEC_W    = 6;
  localparam int unsigned TMR_LOAD = SETTLE_CYCLES + SYNC_STAGES;
  localparam int unsigned TMR_W    = $clog2(TMR_LOAD + 1);
  localparam logic [VEC_W-1:0] LAST_VEC = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    SAMPLE = 2'd3
  } state_t;

  state_t             state;
  logic [VEC_W-1:0]   vec_cnt;
  logic [TMR_W-1:0]   timer;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               q_sync;

  logic               mismatch_c;
  logic               fault_base_c;
  logic [CNT_W-1:0]   cnt_base_c;
  logic [VEC_W-1:0]   vec_base_c;

  // Bring the asynchronous gate output into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], q_in};
    end
  end

  assign q_sync = sync_q[SYNC_STAGES-1];

  // Mismatch detect; clear is folded into the base so a coincident fault counts as the first one
  always_comb begin
    mismatch_c   = (state == SAMPLE) && (q_sync != (^a_out));
    fault_base_c = clear ? 1'b0 : fault;
    cnt_base_c   = clear ? '0 : fault_count;
    vec_base_c   = clear ? '0 : fault_vec;
  end

  // Fault status: sticky flag, saturating count, first faulting vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault       <= 1'b0;
      fault_count <= '0;
      fault_vec   <= '0;
    end else begin
      fault       <= fault_base_c | mismatch_c;
      fault_count <= cnt_base_c;
      fault_vec   <= vec_base_c;
      if (mismatch_c) begin
        if (cnt_base_c != CNT_MAX) begin
          fault_count <= cnt_base_c + CNT_W'(1);
        end
        if (!fault_base_c) begin
          fault_vec <= a_out;
        end
      end
    end
  end

  // Sweep FSM: drive vector, wait settle + sync latency, sample, advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      vec_cnt    <= '0;
      timer      <= '0;
      a_out      <= '0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state <= DRIVE;
            busy  <= 1'b1;
          end
        end
        DRIVE: begin
          a_out <= vec_cnt;
          timer <= TMR_W'(TMR_LOAD);
          state <= SETTLE;
        end
        SETTLE: begin
          if (timer == TMR_W'(1)) begin
            state <= SAMPLE;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        SAMPLE: begin
          vec_cnt    <= vec_cnt + VEC_W'(1);
          sweep_done <= (vec_cnt == LAST_VEC);
          if (run) begin
            state <= DRIVE;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_fault_monitor.sv
// Bench for xor_fault_monitor: models the XOR gate (with injectable faults) and
// checks sweep results through an expectation queue popped on sweep_done.
module tb_xor_fault_monitor;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        clear;
  logic        q_in;
  logic [5:0]  a_out;
  logic        busy;
  logic        sweep_done;
  logic        fault;
  logic [15:0] fault_count;
  logic [5:0]  fault_vec;

  // Second instance with a narrow counter to exercise saturation
  logic        q_in2;
  logic [5:0]  a_out2;
  logic        busy2;
  logic        sweep_done2;
  logic        fault2;
  logic [3:0]  fault_count2;
  logic [5:0]  fault_vec2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_sweep = 0;
  int mode;

  typedef struct {
    logic        f;
    logic [15:0] cnt;
    logic [5:0]  vec;
    int          interval;
  } sweep_exp_t;

  sweep_exp_t exp_q[$];

  xor_fault_monitor dut (
    .clk(clk), .rst_n(rst_n), .run(run), .clear(clear), .q_in(q_in),
    .a_out(a_out), .busy(busy), .sweep_done(sweep_done), .fault(fault),
    .fault_count(fault_count), .fault_vec(fault_vec)
  );

  xor_fault_monitor #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .run(1'b1), .clear(1'b0), .q_in(q_in2),
    .a_out(a_out2), .busy(busy2), .sweep_done(sweep_done2), .fault(fault2),
    .fault_count(fault_count2), .fault_vec(fault_vec2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Gate model: 0 = healthy, 1 = flipped at 6'h2A, 2 = output stuck at 0
  always_comb begin
    case (mode)
      1:       q_in = (^a_out) ^ (a_out == 6'h2A);
      2:       q_in = 1'b0;
      default: q_in = ^a_out;
    endcase
  end

  assign q_in2 = ~(^a_out2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out (t=%0t)", name, $time);
  endtask

  task automatic push_sweep(input logic f, input logic [15:0] cnt, input logic [5:0] vec,
                            input int interval);
    sweep_exp_t e;
    e.f = f; e.cnt = cnt; e.vec = vec; e.interval = interval;
    exp_q.push_back(e);
  endtask

  task automatic wait_sweep();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sweep_done && n < 700);
    if (!sweep_done) timeout_fail("wait_sweep");
  endtask

  task automatic wait_vec(input logic [5:0] v, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (a_out !== v && n < budget);
    if (a_out !== v) timeout_fail("wait_vec");
  endtask

  // Scoreboard monitor: each sweep_done pops one expected end-of-sweep status
  always @(negedge clk) begin
    if (rst_n && sweep_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_sweep_done actual=1 required=0 (t=%0t)", $time);
      end else begin
        sweep_exp_t e;
        e = exp_q.pop_front();
        chk("sweep_fault", 32'(fault), 32'(e.f));
        chk("sweep_fault_count", 32'(fault_count), 32'(e.cnt));
        chk("sweep_fault_vec", 32'(fault_vec), 32'(e.vec));
        if (e.interval != 0) chk("sweep_interval", 32'(cyc - last_sweep), 32'(e.interval));
      end
      last_sweep = cyc;
    end
  end

  // Saturating instance: every vector mismatches, count pins at 15
  always @(negedge clk) begin
    if (rst_n && sweep_done2) begin
      chk("sat_sweep_count", 32'(fault_count2), 32'd15);
      chk("sat_sweep_vec", 32'(fault_vec2), 32'h00);
    end
  end

  initial begin
    @(posedge rst_n);
    repeat (116) @(posedge clk);
    @(negedge clk);
    chk("sat_count_14_vectors", 32'(fault_count2), 32'd14);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("sat_count_15_vectors", 32'(fault_count2), 32'd15);
    chk("sat_fault", 32'(fault2), 32'd1);
  end

  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    clear = 1'b0;
    mode  = 0;
    repeat (3) @(negedge clk);
    chk("rst_a_out", 32'(a_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_fault_count", 32'(fault_count), 32'h0);
    chk("rst_fault_vec", 32'(fault_vec), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'h0);

    // Healthy gate, one sweep
    run = 1'b1;
    push_sweep(1'b0, 16'd0, 6'h00, 0);
    wait_sweep();

    // Single fault at 6'h2A for three sweeps
    mode = 1;
    push_sweep(1'b1, 16'd1, 6'h2A, 512);
    push_sweep(1'b1, 16'd2, 6'h2A, 512);
    push_sweep(1'b1, 16'd3, 6'h2A, 512);
    repeat (3) wait_sweep();

    // Stuck-at-0 output: every odd-parity vector faults
    mode  = 2;
    clear = 1'b1;
    push_sweep(1'b1, 16'd32, 6'h01, 512);
    @(negedge clk);
    clear = 1'b0;
    wait_sweep();

    // Clear coincident with a faulting sample, run dropped mid-settle
    wait_vec(6'h07, 200);
    repeat (3) @(posedge clk);
    #1 run = 1'b0;
    repeat (3) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    chk("clr_fault", 32'(fault), 32'h1);
    chk("clr_fault_count", 32'(fault_count), 32'h1);
    chk("clr_fault_vec", 32'(fault_vec), 32'h07);
    chk("stop_busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    chk("stop_busy_held", 32'(busy), 32'h0);
    chk("stop_a_out_held", 32'(a_out), 32'h07);
    run = 1'b1;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (a_out === 6'h07 && n < 20);
    end
    chk("resume_next_vec", 32'(a_out), 32'h08);

    // Async reset mid-settle with fault set
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_a_out", 32'(a_out), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_fault", 32'(fault), 32'h0);
    chk("arst_fault_count", 32'(fault_count), 32'h0);
    chk("arst_fault_vec", 32'(fault_vec), 32'h0);
    chk("arst_sweep_done", 32'(sweep_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'h1);
    chk("post_rst_first_vec", 32'(a_out), 32'h00);
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("post_rst_vec0_hold", 32'(a_out), 32'h00);
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_second_vec", 32'(a_out), 32'h01);

    run = 1'b0;
    repeat (20) @(negedge clk);
    chk("sweep_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
